mem_xlate_stage: RTL

- Pipeline register stage directly downstream of the address translation unit.
- Captures VA, access type and translation results (PA, MAT, TLB fault flags) for one memory access (fetch, load or store).
- Classifies the LoongArch address/TLB exception with fixed priority, then either issues a cache request or presents an exception record, using valid/ready handshakes.
- Single-entry buffer; supports flush.

---
 rtl/mem_xlate_stage_pkg.sv | 59 +++++
 rtl/mem_xlate_stage_classify.sv | 49 ++++
 rtl/mem_xlate_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_xlate_stage_pkg.sv
// Shared types and constants for the post-translation memory stage.
package mem_xlate_stage_pkg;

    localparam int ECODE_WIDTH = 6;

    localparam logic [ECODE_WIDTH-1:0] ECODE_NONE = 6'h00;
    localparam logic [ECODE_WIDTH-1:0] ECODE_PIL  = 6'h01;
    localparam logic [ECODE_WIDTH-1:0] ECODE_PIS  = 6'h02;
    localparam logic [ECODE_WIDTH-1:0] ECODE_PIF  = 6'h03;
    localparam logic [ECODE_WIDTH-1:0] ECODE_PME  = 6'h04;
    localparam logic [ECODE_WIDTH-1:0] ECODE_PPI  = 6'h07;
    localparam logic [ECODE_WIDTH-1:0] ECODE_ADE  = 6'h08;
    localparam logic [ECODE_WIDTH-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_WIDTH-1:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_EXC   = 2'd2
    } state_e;

    // One buffered access; uncached/we are resolved at capture time so the
    // reset value of every output field is zero.
    typedef struct packed {
        logic [31:0]            pa;
        logic [31:0]            va;
        logic                   uncached;
        logic                   we;
        logic [1:0]             size;
        logic                   has_exc;
        logic [ECODE_WIDTH-1:0] ecode;
    } xlate_buf_t;

    // Data access alignment check: half needs va[0]==0, word needs va[1:0]==0.
    function automatic logic data_misaligned(input logic [1:0] size, input logic [1:0] va_lo);
        logic mis;
        case (size)
            SIZE_HALF: mis = va_lo[0];
            SIZE_WORD: mis = (va_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_xlate_stage_classify.sv
// Fixed-priority address/TLB exception classifier for one memory access.
module mem_exc_classify
    import mem_xlate_stage_pkg::*;
(
    input  logic [1:0]             in_kind,
    input  logic [1:0]             in_size,
    input  logic [31:0]            in_va,
    input  logic                   in_tlb_used,
    input  logic                   in_page_fault,
    input  logic                   in_page_invalid,
    input  logic                   in_page_dirty,
    input  logic                   in_plv_fault,
    output logic                   has_exc,
    output logic [ECODE_WIDTH-1:0] ecode
);

    logic is_fetch_s;
    logic is_store_s;

    assign is_fetch_s = (in_kind == KIND_FETCH);
    assign is_store_s = (in_kind == KIND_STORE);

    // Highest-priority matching exception wins; TLB flags only count via the TLB.
    always_comb begin
        has_exc = 1'b1;
        ecode   = ECODE_NONE;
        if (is_fetch_s && (in_va[1:0] != 2'b00)) begin
            ecode = ECODE_ADE;
        end else if (!is_fetch_s && data_misaligned(in_size, in_va[1:0])) begin
            ecode = ECODE_ALE;
        end else if (in_tlb_used && in_page_fault) begin
            ecode = ECODE_TLBR;
        end else if (in_tlb_used && in_page_invalid) begin
            case (in_kind)
                KIND_FETCH: ecode = ECODE_PIF;
                KIND_STORE: ecode = ECODE_PIS;
                default:    ecode = ECODE_PIL;
            endcase
        end else if (in_tlb_used && in_plv_fault) begin
            ecode = ECODE_PPI;
        end else if (is_store_s && in_tlb_used && !in_page_dirty) begin
            ecode = ECODE_PME;
        end else begin
            has_exc = 1'b0;
            ecode   = ECODE_NONE;
        end
    end

endmodule

// File: rtl/mem_xlate_stage.sv
// Single-entry stage after address translation: issues a cache request or
// presents an exception record, with valid/ready on both sides.
module mem_xlate_stage
    import mem_xlate_stage_pkg::*;
#(
    parameter int ECODE_W = ECODE_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_kind,
    input  logic [1:0]         in_size,
    input  logic [31:0]        in_va,
    input  logic [31:0]        in_pa,
    input  logic [1:0]         in_mat,
    input  logic               in_tlb_used,
    input  logic               in_page_fault,
    input  logic               in_page_invalid,
    input  logic               in_page_dirty,
    input  logic               in_plv_fault,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [31:0]        req_pa,
    output logic               req_uncached,
    output logic               req_we,
    output logic [1:0]         req_size,
    output logic               exc_valid,
    input  logic               exc_ready,
    output logic [ECODE_W-1:0] exc_ecode,
    output logic [31:0]        exc_badv
);

    state_e                 state_q, state_d;
    xlate_buf_t             buf_q, buf_d;
    logic                   req_valid_q, exc_valid_q;
    logic                   has_exc_s;
    logic [ECODE_WIDTH-1:0] ecode_s;
    logic                   in_ready_s;
    logic                   capture_s;

    mem_exc_classify u_classify (
        .in_kind         (in_kind),
        .in_size         (in_size),
        .in_va           (in_va),
        .in_tlb_used     (in_tlb_used),
        .in_page_fault   (in_page_fault),
        .in_page_invalid (in_page_invalid),
        .in_page_dirty   (in_page_dirty),
        .in_plv_fault    (in_plv_fault),
        .has_exc         (has_exc_s),
        .ecode           (ecode_s)
    );

    // Ready when the slot is empty or is being drained this same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_EMPTY: in_ready_s = !flush;
            ST_REQ:   in_ready_s = !flush && req_ready;
            ST_EXC:   in_ready_s = !flush && exc_ready;
            default:  in_ready_s = 1'b0;
        endcase
    end

    assign capture_s = in_valid && in_ready_s;

    // Next-state: flush dominates, then capture, then drain on handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (capture_s) begin
            state_d = has_exc_s ? ST_EXC : ST_REQ;
        end else begin
            case (state_q)
                ST_REQ:   state_d = req_ready ? ST_EMPTY : ST_REQ;
                ST_EXC:   state_d = exc_ready ? ST_EMPTY : ST_EXC;
                ST_EMPTY: state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Assemble the record to buffer from the incoming access.
    always_comb begin
        buf_d          = '0;
        buf_d.pa       = in_pa;
        buf_d.va       = in_va;
        buf_d.uncached = (in_mat == 2'd0);
        buf_d.we       = (in_kind == KIND_STORE);
        buf_d.size     = in_size;
        buf_d.has_exc  = has_exc_s;
        buf_d.ecode    = ecode_s;
    end

    // State register plus registered valid flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            req_valid_q <= 1'b0;
            exc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= (state_d == ST_REQ);
            exc_valid_q <= (state_d == ST_EXC);
        end
    end

    // Payload register; only changes on capture so fields stay stable under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else if (capture_s) begin
            buf_q <= buf_d;
        end else begin
            buf_q <= buf_q;
        end
    end

    assign in_ready     = in_ready_s;
    assign req_valid    = req_valid_q;
    assign req_pa       = buf_q.pa;
    assign req_uncached = buf_q.uncached;
    assign req_we       = buf_q.we;
    assign req_size     = buf_q.size;
    assign exc_valid    = exc_valid_q;
    assign exc_ecode    = ECODE_W'(buf_q.ecode);
    assign exc_badv     = buf_q.va;

endmodule
